// File: rtl/bi_dir_buf_ctrl.sv
// Direction controller for the shared bidirectional buffer: grants send or receive,
// inserts dead cycles between grants and caps bursts when the other side is waiting.
module bi_dir_buf_ctrl #(
    parameter int unsigned TURN_CYCLES = 2,
    parameter int unsigned MAX_BURST   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_req,
    input  logic        rx_req,
    output logic        send_data,
    output logic        recv_data,
    output logic        turn_active,
    output logic        last_dir,
    output logic [15:0] xfer_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RECV = 2'd2,
        TURN = 2'd3
    } state_e;

    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);
    localparam logic [3:0] TURN_MAX  = 4'(TURN_CYCLES);

    state_e      state_q;
    logic        send_q;
    logic        recv_q;
    logic        turn_q;
    logic        last_dir_q;
    logic [15:0] xfer_q;
    logic [7:0]  burst_q;
    logic [3:0]  turn_cnt_q;

    logic pick_send;
    logic pick_recv;
    logic arb_now;

    // A tie goes to the direction that did not have the most recent grant.
    always_comb begin
        pick_send = tx_req && (!rx_req || !last_dir_q);
        pick_recv = rx_req && (!tx_req || last_dir_q);
        arb_now   = (state_q == IDLE) ||
                    ((state_q == TURN) && (turn_cnt_q >= TURN_MAX));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            send_q     <= 1'b0;
            recv_q     <= 1'b0;
            turn_q     <= 1'b0;
            last_dir_q <= 1'b0;
            xfer_q     <= 16'd0;
            burst_q    <= 8'd0;
            turn_cnt_q <= 4'd0;
        end else begin
            xfer_q <= xfer_q + {15'd0, (send_q | recv_q)};
            if (arb_now) begin
                turn_q     <= 1'b0;
                turn_cnt_q <= 4'd0;
                if (pick_send) begin
                    state_q    <= SEND;
                    send_q     <= 1'b1;
                    last_dir_q <= 1'b1;
                    burst_q    <= 8'd1;
                end else if (pick_recv) begin
                    state_q    <= RECV;
                    recv_q     <= 1'b1;
                    last_dir_q <= 1'b0;
                    burst_q    <= 8'd1;
                end else begin
                    state_q <= IDLE;
                end
            end else begin
                case (state_q)
                    SEND: begin
                        if (!tx_req || ((burst_q >= BURST_MAX) && rx_req)) begin
                            state_q    <= TURN;
                            send_q     <= 1'b0;
                            turn_q     <= 1'b1;
                            turn_cnt_q <= 4'd1;
                            burst_q    <= 8'd0;
                        end else if (burst_q < BURST_MAX) begin
                            burst_q <= burst_q + 8'd1;
                        end
                    end
                    RECV: begin
                        if (!rx_req || ((burst_q >= BURST_MAX) && tx_req)) begin
                            state_q    <= TURN;
                            recv_q     <= 1'b0;
                            turn_q     <= 1'b1;
                            turn_cnt_q <= 4'd1;
                            burst_q    <= 8'd0;
                        end else if (burst_q < BURST_MAX) begin
                            burst_q <= burst_q + 8'd1;
                        end
                    end
                    TURN: begin
                        turn_cnt_q <= turn_cnt_q + 4'd1;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign send_data   = send_q;
    assign recv_data   = recv_q;
    assign turn_active = turn_q;
    assign last_dir    = last_dir_q;
    assign xfer_cnt    = xfer_q;

endmodule

// File: tb/tb_bi_dir_buf_ctrl.sv
// Bench for bi_dir_buf_ctrl: directed steps push the expected outputs for the next
// cycle; a monitor pops and compares, and a separate checker watches the invariants.
module tb_bi_dir_buf_ctrl;

  logic        clk;
  logic        rst_n;
  logic        tx_req;
  logic        rx_req;
  logic        send_data;
  logic        recv_data;
  logic        turn_active;
  logic        last_dir;
  logic [15:0] xfer_cnt;

  int checks;
  int errors;

  // each entry: {send, recv, turn, last_dir, xfer_cnt}
  logic [19:0] exp_q[$];
  string       name_q[$];

  bi_dir_buf_ctrl #(.TURN_CYCLES(2), .MAX_BURST(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tx_req(tx_req),
    .rx_req(rx_req),
    .send_data(send_data),
    .recv_data(recv_data),
    .turn_active(turn_active),
    .last_dir(last_dir),
    .xfer_cnt(xfer_cnt)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver: inputs applied on the falling edge, expectation is the state after the next rising edge
  task automatic step(input logic rn, input logic tx, input logic rx,
                      input logic [3:0] f, input logic [15:0] cnt, input string nm);
    @(negedge clk);
    rst_n  = rn;
    tx_req = tx;
    rx_req = rx;
    exp_q.push_back({f, cnt});
    name_q.push_back(nm);
  endtask

  // scoreboard monitor
  logic [19:0] mon_e;
  string       mon_nm;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      checks++;
      if ({send_data, recv_data, turn_active, last_dir} !== mon_e[19:16]) begin
        errors++;
        $display("FAIL %s flags(s,r,t,l) got %b expected %b at %0t", mon_nm,
                 {send_data, recv_data, turn_active, last_dir}, mon_e[19:16], $time);
      end
      checks++;
      if (xfer_cnt !== mon_e[15:0]) begin
        errors++;
        $display("FAIL %s xfer_cnt got %0d expected %0d at %0t", mon_nm,
                 xfer_cnt, mon_e[15:0], $time);
      end
    end
  end

  // invariant checker: exclusive enables and a dead gap of at least 2 between grants
  int   dead;
  logic prev_en;
  initial begin
    dead    = 99;
    prev_en = 1'b0;
  end
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      dead    = 99;
      prev_en = 1'b0;
    end else begin
      checks++;
      if (send_data === 1'b1 && recv_data === 1'b1) begin
        errors++;
        $display("FAIL overlap send=%b recv=%b at %0t", send_data, recv_data, $time);
      end
      if ((send_data === 1'b1 || recv_data === 1'b1) && !prev_en) begin
        checks++;
        if (dead < 2) begin
          errors++;
          $display("FAIL dead_gap got %0d required >= 2 at %0t", dead, $time);
        end
      end
      prev_en = (send_data === 1'b1 || recv_data === 1'b1);
      if (prev_en) dead = 0;
      else dead++;
    end
  end

  logic [15:0] g;
  logic [3:0]  f;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    tx_req = 1'b0;
    rx_req = 1'b0;

    // reset held with both requests high, then release: tie goes to send
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 4'b0000, 16'd0, "reset_hold");
    step(1'b1, 1'b1, 1'b1, 4'b1001, 16'd0, "reset_release");
    step(1'b1, 1'b0, 1'b0, 4'b0011, 16'd1, "reset_turn1");
    step(1'b1, 1'b0, 1'b0, 4'b0011, 16'd1, "reset_turn2");
    step(1'b1, 1'b0, 1'b0, 4'b0001, 16'd1, "reset_idle");

    // single send of 5 cycles
    step(1'b0, 1'b0, 1'b0, 4'b0000, 16'd0, "single_rst");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 4'b1001, 16'(i), "single_send");
    step(1'b1, 1'b0, 1'b0, 4'b0011, 16'd5, "single_turn1");
    step(1'b1, 1'b0, 1'b0, 4'b0011, 16'd5, "single_turn2");
    step(1'b1, 1'b0, 1'b0, 4'b0001, 16'd5, "single_idle");
    step(1'b1, 1'b0, 1'b0, 4'b0001, 16'd5, "single_idle2");

    // contention: 8 send / 2 dead / 8 recv / 2 dead
    step(1'b0, 1'b0, 1'b0, 4'b0000, 16'd0, "cont_rst");
    g = 16'd0;
    for (int c = 0; c < 40; c++) begin
      if (c % 20 < 8)       f = 4'b1001;
      else if (c % 20 < 10) f = 4'b0011;
      else if (c % 20 < 18) f = 4'b0100;
      else                  f = 4'b0010;
      step(1'b1, 1'b1, 1'b1, f, g, "contention");
      if (f[3] || f[2]) g = g + 16'd1;
    end
    step(1'b1, 1'b0, 1'b0, 4'b0000, 16'd32, "cont_idle");

    // tx alone keeps the grant past the burst limit
    step(1'b0, 1'b0, 1'b0, 4'b0000, 16'd0, "nostarve_rst");
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 4'b1001, 16'(i), "nostarve_send");
    step(1'b1, 1'b0, 1'b0, 4'b0011, 16'd20, "nostarve_turn");
    step(1'b1, 1'b0, 1'b0, 4'b0011, 16'd20, "nostarve_turn2");
    step(1'b1, 1'b0, 1'b0, 4'b0001, 16'd20, "nostarve_idle");

    // reset in the 4th send cycle, then in the 1st turn cycle
    step(1'b0, 1'b0, 1'b0, 4'b0000, 16'd0, "midrst_rst");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 4'b1001, 16'(i), "midrst_send");
    step(1'b0, 1'b1, 1'b0, 4'b0000, 16'd0, "midrst_in_send");
    step(1'b1, 1'b1, 1'b0, 4'b1001, 16'd0, "midrst_regrant");
    step(1'b1, 1'b0, 1'b0, 4'b0011, 16'd1, "midrst_turn");
    step(1'b0, 1'b0, 1'b0, 4'b0000, 16'd0, "midrst_in_turn");
    step(1'b1, 1'b0, 1'b1, 4'b0100, 16'd0, "midrst_recv");
    step(1'b1, 1'b0, 1'b0, 4'b0010, 16'd1, "midrst_rturn1");
    step(1'b1, 1'b0, 1'b0, 4'b0010, 16'd1, "midrst_rturn2");
    step(1'b1, 1'b0, 1'b0, 4'b0000, 16'd1, "midrst_idle");

    // xfer_cnt wrap after 65536+3 granted cycles
    step(1'b0, 1'b0, 1'b0, 4'b0000, 16'd0, "wrap_rst");
    for (int i = 0; i < 65539; i++) step(1'b1, 1'b1, 1'b0, 4'b1001, 16'(i), "wrap_send");
    step(1'b1, 1'b0, 1'b0, 4'b0011, 16'd3, "wrap_final");
    step(1'b1, 1'b0, 1'b0, 4'b0011, 16'd3, "wrap_turn2");

    // bounded drain of the expected queue
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain queue has %0d entries expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bi_dir_buf_ctrl.md
# bi_dir_buf_ctrl

Direction controller and arbiter for the 3-bit bidirectional buffer. Two requesters (transmit side, receive side) share the buffer. The block grants one direction at a time and drives the buffer's `send_data` / `recv_data` enables. It enforces a dead-cycle turnaround between direction changes and bounds burst length so neither side starves. It sits between the requesting logic and the `bi_dir_buf` instance.

## Interface

Parameters:
- `TURN_CYCLES`, default 2: dead cycles (both enables 0) after any grant ends. Legal range 1–15.
- `MAX_BURST`, default 8: grant cycles after which the other pending requester takes over. Legal range 1–255.

Ports:
- `clk`, input, 1: single clock; all logic on rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `tx_req`, input, 1: transmit side requests the buffer in send direction.
- `rx_req`, input, 1: receive side requests the buffer in receive direction.
- `send_data`, output, 1: buffer send enable; doubles as transmit grant.
- `recv_data`, output, 1: buffer receive enable; doubles as receive grant.
- `turn_active`, output, 1: high during turnaround dead cycles.
- `last_dir`, output, 1: direction of the most recent grant (1 = send, 0 = receive).
- `xfer_cnt`, output, 16: total granted cycles since reset; wraps from 0xFFFF to 0.

## Operation

- States: IDLE, SEND, RECV, TURN. All outputs are registered and decoded from state and counters.
- Reset (`rst_n`=0 at an edge) forces the following, regardless of current state, including mid-burst or mid-turn:
  - state = IDLE
  - `send_data` = 0, `recv_data` = 0, `turn_active` = 0
  - `last_dir` = 0, `xfer_cnt` = 0, burst counter = 0, turn counter = 0
- Arbitration, applied in IDLE and on the final TURN cycle:
  - Only `tx_req` high → SEND.
  - Only `rx_req` high → RECV.
  - Both high → the direction opposite `last_dir`. After reset, `last_dir` = 0, so SEND wins the first tie.
  - Neither high → IDLE.
- SEND / RECV:
  - Each cycle in the state increments the burst counter (saturates at MAX_BURST) and `xfer_cnt`. `last_dir` updates on entry.
  - Exit to TURN when the own request is low, or when the burst counter has reached MAX_BURST and the other request is high.
  - If only the own request remains high, the grant continues beyond MAX_BURST.
- TURN:
  - Lasts exactly TURN_CYCLES cycles, counted by the turn counter. On its last cycle, run arbitration to pick the next state.
  - The burst counter clears on TURN entry.
- Invariants:
  - `send_data` and `recv_data` are never both 1.
  - A 1→0 on either enable is followed by at least TURN_CYCLES cycles with both enables 0 before either enable is 1 again. This holds even if the same direction is re-granted.
- Requests are level-sensitive. The block does not latch requests: a request dropped during TURN is lost.

## Timing

- Request latency: a request sampled high at edge N in IDLE → its enable is high after edge N+1 (one cycle).
- Release latency: own request sampled low at edge N in SEND/RECV → enable low and `turn_active` high after edge N+1.
- Turnaround: `turn_active` is high for TURN_CYCLES cycles. The next enable can rise at the earliest on the cycle immediately after the last TURN cycle.
- Forced switch: with both requests held high continuously, enables alternate in this pattern, repeating:
  - MAX_BURST cycles of send
  - TURN_CYCLES cycles dead
  - MAX_BURST cycles of receive
  - TURN_CYCLES cycles dead
- `xfer_cnt` increments in the same cycle that an enable is high; its value is visible the following cycle.

## Test plan

- **Reset:** hold `rst_n`=0 for 3 cycles with `tx_req`=`rx_req`=1 → all outputs 0. Release → `send_data`=1 exactly 1 cycle later (tie goes to send).
- **Single send:** `tx_req`=1 for 5 cycles, then 0 → `send_data` high 5 cycles, `turn_active` high 2 cycles, IDLE, `xfer_cnt`=5.
- **Contention:** both requests held high for 40 cycles with defaults → pattern of 8 send / 2 dead / 8 recv / 2 dead, repeating. Checker confirms the two enables are never high together and the dead-cycle gap is never under 2.
- **No starvation beyond burst:** `tx_req` held high for 20 cycles, `rx_req`=0 → `send_data` high continuously for 20 cycles with no forced TURN.
- **Reset mid-operation:** assert `rst_n`=0 in the 4th SEND cycle, and separately in the 1st TURN cycle → next cycle all outputs 0 and state IDLE. The first grant after reset follows the IDLE latency rule.
- **Wrap:** run with `xfer_cnt` preloaded near the top by driving 65536+3 granted cycles → `xfer_cnt`=3.
